vdc_vram_arbiter: RTL and testbench

Sequences all VRAM accesses of the HuC6270 VDC, sharing the single 16-bit VRAM bus (MA, MRD_n, MWR_n, read/write data) between four requesters: background fetch, sprite fetch, CPU port (MAWR/MARR path) and VRAM-VRAM DMA. It sits between the VDC's internal fetch/CPU/DMA engines and the external VRAM pins. Every access is a fixed three-clock transaction. Priority depends on the display phase, and the CPU is protected against starvation.

---
 rtl/vdc_vram_arbiter_if.sv | 24 ++
 rtl/vdc_vram_arbiter.sv | 60 ++++++
 tb/tb_vdc_vram_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vdc_vram_arbiter_if.sv
// vdc_vram_arbiter_if: requester handshake plus VRAM pin bundle for the VDC VRAM arbiter.
interface vdc_vram_arbiter_if;
  logic        active;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [3:0]  ack;
  logic [15:0] rdata;
  logic [15:0] MA;
  logic        MRD_n;
  logic        MWR_n;
  logic [15:0] DO;
  logic [15:0] DI;
  logic        busy;
  modport slave (
    input  active, req, we, addr, wdata, DI,
    output ack, rdata, MA, MRD_n, MWR_n, DO, busy
  );
  modport master (
    output active, req, we, addr, wdata, DI,
    input  ack, rdata, MA, MRD_n, MWR_n, DO, busy
  );
endinterface

// File: rtl/vdc_vram_arbiter.sv
// vdc_vram_arbiter: three-clock VRAM access sequencer for bg/spr/cpu/dma with phase priority
// and a CPU starvation guard.
module vdc_vram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clock,
  input logic               reset_N,
  vdc_vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_ARB, S_DATA, S_DONE} state_t;
  state_t      state, state_nx;
  logic [1:0]  win, pick;
  logic        wr, starve, grant;
  logic [2:0]  cpu_wait;
  logic [15:0] ma_q, do_q, rdata_q;
  assign starve = bus.req[2] && cpu_wait == 3'(STARVE_LIMIT);
  assign grant  = state == S_ARB && |bus.req;
  // Active display favours the fetch engines; blanking favours the CPU and DMA.
  always_comb
    pick = starve ? 2'd2 :
           bus.active ? (bus.req[0] ? 2'd0 : bus.req[1] ? 2'd1 : bus.req[2] ? 2'd2 : 2'd3) :
                        (bus.req[2] ? 2'd2 : bus.req[3] ? 2'd3 : bus.req[1] ? 2'd1 : 2'd0);
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) state <= S_ARB;
    else          state <= state_nx;
  always_comb
    state_nx = state == S_ARB  ? (|bus.req ? S_DATA : S_ARB) :
               state == S_DATA ? S_DONE : S_ARB;
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) begin
      win      <= 2'd0;
      wr       <= 1'b0;
      ma_q     <= 16'd0;
      do_q     <= 16'd0;
      rdata_q  <= 16'd0;
      cpu_wait <= 3'd0;
    end else begin
      if (grant) begin
        win  <= pick;
        wr   <= pick[1] & bus.we[pick];
        ma_q <= bus.addr[{pick, 4'b0} +: 16];
        do_q <= bus.wdata[{pick, 4'b0} +: 16];
      end
      if (state == S_DATA && !wr) rdata_q <= bus.DI;
      if (!bus.req[2])
        cpu_wait <= 3'd0;
      else if (grant)
        cpu_wait <= pick == 2'd2 ? 3'd0 : cpu_wait == 3'(STARVE_LIMIT) ? cpu_wait : cpu_wait + 3'd1;
    end
  // Strobes and ack decode straight from state so reset releases them immediately.
  always_comb begin
    bus.busy  = state != S_ARB;
    bus.MRD_n = !(state == S_DATA && !wr);
    bus.MWR_n = !(state == S_DATA && wr);
    bus.ack   = state == S_DONE ? 4'b1 << win : 4'b0;
  end
  assign bus.MA    = ma_q;
  assign bus.DO    = do_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_vdc_vram_arbiter.sv
// tb_vdc_vram_arbiter: directed and randomized checks of the VRAM arbiter against a
// transaction-level model with a cycle-stamped grant timeline.
module tb_vdc_vram_arbiter;
  localparam int STARVE = 4;
  logic        clock = 1'b0;
  logic        reset_N = 1'b0;
  logic        di_force = 1'b0;
  logic [15:0] di_val = 16'd0;
  int          checks = 0;
  int          errors = 0;
  bit          run_cmp = 1'b0;
  int          cyc = 0;
  int          g = -10;
  int          gwin = 0;
  bit          gw = 1'b0;
  int          m_wait = 0;
  int          nw;
  logic [1:0]  ni;
  logic [15:0] e_ma = 16'd0;
  logic [15:0] e_do = 16'd0;
  logic [15:0] e_rdata = 16'd0;
  int          act_ord[4] = '{0, 1, 2, 3};
  int          blank_ord[4] = '{2, 3, 1, 0};

  vdc_vram_arbiter_if bus();
  vdc_vram_arbiter #(.STARVE_LIMIT(STARVE)) dut (.clock(clock), .reset_N(reset_N), .bus(bus));

  always #5 clock = ~clock;

  function automatic logic [15:0] dfun(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  assign bus.DI = di_force ? di_val : dfun(bus.MA);

  function automatic int pick_m(logic [3:0] r, logic act, int wt);
    if (r[2] && wt == STARVE) return 2;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = act ? act_ord[i] : blank_ord[i];
      if (r[k]) return k;
    end
    return -1;
  endfunction

  always_comb begin
    nw = pick_m(bus.req, bus.active, m_wait);
    ni = nw[1:0];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: g is the cycle number of the strobe cycle of the latest grant; the
  // following cycle carries the ack, and arbitration resumes one cycle later.
  always @(posedge clock or negedge reset_N)
    if (!reset_N) begin
      g       <= -10;
      m_wait  <= 0;
      e_ma    <= 16'd0;
      e_do    <= 16'd0;
      e_rdata <= 16'd0;
    end else begin
      cyc <= cyc + 1;
      if (cyc == g && !gw) e_rdata <= di_force ? di_val : dfun(e_ma);
      if (cyc + 1 >= g + 3 && bus.req != 4'd0) begin
        g    <= cyc + 1;
        gwin <= nw;
        gw   <= nw >= 2 && bus.we[ni];
        e_ma <= bus.addr[16*nw +: 16];
        e_do <= bus.wdata[16*nw +: 16];
        m_wait <= !bus.req[2] ? 0 : nw == 2 ? 0 : m_wait < STARVE ? m_wait + 1 : m_wait;
      end else if (!bus.req[2]) m_wait <= 0;
    end

  always @(negedge clock)
    if (run_cmp) begin
      bit stb, dn;
      stb = cyc == g;
      dn  = cyc == g + 1;
      chk("busy", bus.busy, stb | dn);
      chk("MRD_n", bus.MRD_n, !(stb && !gw));
      chk("MWR_n", bus.MWR_n, !(stb && gw));
      chk("ack", bus.ack, dn ? 32'd1 << gwin : 32'd0);
      chk("MA", bus.MA, e_ma);
      chk("DO", bus.DO, e_do);
      chk("rdata", bus.rdata, e_rdata);
    end

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int i = 0; i < 12 && idx < 0; i++) begin
      @(negedge clock);
      for (int k = 3; k >= 0; k--) if (bus.ack[k]) idx = k;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_wait no ack within 12 cycles at cycle %0d", cyc);
    end
  endtask

  task automatic run_prio(input logic act, input int e0, input int e1, input int e2, input int e3);
    int exp[4];
    int idx;
    exp = '{e0, e1, e2, e3};
    bus.active = act;
    bus.we = 4'd0;
    bus.req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wait_ack(idx);
      chk("prio_order", idx, exp[i]);
      if (idx >= 0) bus.req[idx] = 1'b0;
    end
    bus.req = 4'd0;
    @(negedge clock);
  endtask

  initial begin
    int idx;
    int sexp[6];
    sexp = '{0, 0, 0, 0, 2, 0};
    bus.active = 1'b0;
    bus.req = 4'd0;
    bus.we = 4'd0;
    bus.addr = 64'd0;
    bus.wdata = 64'd0;
    repeat (3) @(negedge clock);
    chk("rst_busy", bus.busy, 0);
    chk("rst_MRD_n", bus.MRD_n, 1);
    chk("rst_MWR_n", bus.MWR_n, 1);
    chk("rst_ack", bus.ack, 0);
    chk("rst_MA", bus.MA, 0);
    chk("rst_DO", bus.DO, 0);
    chk("rst_rdata", bus.rdata, 0);
    reset_N = 1'b1;
    run_cmp = 1'b1;
    @(negedge clock);
    // Single CPU read
    di_force = 1'b1;
    di_val = 16'hBEEF;
    bus.addr[47:32] = 16'h1234;
    bus.req = 4'b0100;
    @(negedge clock);
    chk("rd_MA", bus.MA, 16'h1234);
    chk("rd_MRD_n", bus.MRD_n, 0);
    chk("rd_MWR_n", bus.MWR_n, 1);
    @(negedge clock);
    chk("rd_ack", bus.ack, 4'b0100);
    chk("rd_rdata", bus.rdata, 16'hBEEF);
    chk("rd_MRD_n_hi", bus.MRD_n, 1);
    bus.req = 4'd0;
    @(negedge clock);
    chk("rd_ack_end", bus.ack, 0);
    chk("rd_busy_end", bus.busy, 0);
    // CPU write
    bus.addr[47:32] = 16'h00FF;
    bus.wdata[47:32] = 16'h5A5A;
    bus.we = 4'b0100;
    bus.req = 4'b0100;
    @(negedge clock);
    chk("wr_MWR_n", bus.MWR_n, 0);
    chk("wr_MRD_n", bus.MRD_n, 1);
    chk("wr_DO", bus.DO, 16'h5A5A);
    chk("wr_MA", bus.MA, 16'h00FF);
    @(negedge clock);
    chk("wr_ack", bus.ack, 4'b0100);
    chk("wr_rdata_kept", bus.rdata, 16'hBEEF);
    bus.req = 4'd0;
    bus.we = 4'd0;
    @(negedge clock);
    // Background write enable is ignored
    bus.addr[15:0] = 16'h0042;
    bus.we = 4'b0001;
    bus.req = 4'b0001;
    @(negedge clock);
    chk("bgw_MRD_n", bus.MRD_n, 0);
    chk("bgw_MWR_n", bus.MWR_n, 1);
    @(negedge clock);
    chk("bgw_ack", bus.ack, 4'b0001);
    bus.req = 4'd0;
    bus.we = 4'd0;
    di_force = 1'b0;
    @(negedge clock);
    // Priority by display phase
    run_prio(1'b1, 0, 1, 2, 3);
    run_prio(1'b0, 2, 3, 1, 0);
    // Starvation guard: four bg grants, then the CPU, then bg again with a cleared counter
    bus.active = 1'b1;
    bus.req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      wait_ack(idx);
      chk("starve_order", idx, sexp[i]);
      if (idx == 2) bus.req[2] = 1'b0;
    end
    bus.req = 4'd0;
    @(negedge clock);
    // Reset during the strobe cycle of a DMA write
    bus.addr[63:48] = 16'h7777;
    bus.wdata[63:48] = 16'h1357;
    bus.we = 4'b1000;
    bus.req = 4'b1000;
    @(negedge clock);
    chk("mrst_MWR_n_lo", bus.MWR_n, 0);
    #2 reset_N = 1'b0;
    #1;
    chk("mrst_MWR_n", bus.MWR_n, 1);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_ack", bus.ack, 0);
    @(negedge clock);
    @(negedge clock);
    reset_N = 1'b1;
    wait_ack(idx);
    chk("mrst_retry", idx, 3);
    bus.req = 4'd0;
    bus.we = 4'd0;
    @(negedge clock);
    // Randomized traffic
    repeat (3000) begin
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) bus.active = ~bus.active;
      for (int n = 0; n < 4; n++)
        if (!(bus.req[n] && !bus.ack[n])) begin
          bus.req[n] = $urandom_range(0, 9) < 6;
          bus.we[n] = 1'($urandom_range(0, 1));
          bus.addr[16*n +: 16] = 16'($urandom);
          bus.wdata[16*n +: 16] = 16'($urandom);
        end
    end
    bus.req = 4'd0;
    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
